video_timing_gen: RTL

- Parametrised raster timing generator for arcade cores. Successor to the fixed 9-bit Tetris-era generator.
- Generates pixel/line counters, H/V blanking, H/V sync with selectable polarity, line/frame strobes and a blanked RGB output.
- Totals, active area, sync position/width and colour width are parameters. Sync position can be nudged at run time (OSD screen-centering) without tearing.
- Sits between the core's video pipeline and the scan doubler / VGA output.

---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/timing_axis.sv | 60 ++++++
 rtl/video_timing_gen.sv | 95 +++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing constants and the configuration legality check for the raster generator.
package video_timing_pkg;

    // 448x262 arcade raster
    localparam int unsigned ARC448_H_TOTAL  = 448;
    localparam int unsigned ARC448_H_ACTIVE = 336;
    localparam int unsigned ARC448_HS_START = 352;
    localparam int unsigned ARC448_HS_WIDTH = 32;
    localparam int unsigned ARC448_V_TOTAL  = 262;
    localparam int unsigned ARC448_V_ACTIVE = 240;
    localparam int unsigned ARC448_VS_START = 248;
    localparam int unsigned ARC448_VS_WIDTH = 3;

    // 384x264 raster
    localparam int unsigned ARC384_H_TOTAL  = 384;
    localparam int unsigned ARC384_H_ACTIVE = 256;
    localparam int unsigned ARC384_HS_START = 280;
    localparam int unsigned ARC384_HS_WIDTH = 32;
    localparam int unsigned ARC384_V_TOTAL  = 264;
    localparam int unsigned ARC384_V_ACTIVE = 224;
    localparam int unsigned ARC384_VS_START = 236;
    localparam int unsigned ARC384_VS_WIDTH = 3;

    // Offset range of the run-time sync nudge
    localparam int unsigned OFS_MAG = 8;

    // True when an axis keeps its sync pulse clear of the active area and the
    // wrap for every offset in -8..+7, and the total fits the counter width.
    function automatic bit axis_legal(int unsigned total, int unsigned active,
                                      int unsigned start, int unsigned width,
                                      int unsigned cw);
        return (start >= active + OFS_MAG) &&
               (start + width + (OFS_MAG - 32'd1) <= total - 32'd1) &&
               (total <= (32'd1 << cw));
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter plus registered blank and sync decode, advanced by adv.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned W        = 9,
    parameter int unsigned TOTAL    = 448,
    parameter int unsigned ACTIVE   = 336,
    parameter int unsigned START    = 352,
    parameter int unsigned SWIDTH   = 32,
    parameter bit          POL      = 1'b0,
    parameter bit          ZERO_CLR = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic [3:0]   ofs,
    output logic [W-1:0] cnt,
    output logic         last_c,
    output logic         blank,
    output logic         sync
);

    logic [W-1:0] nxt_c;
    logic [W:0]   nxt_ext_c;
    logic [W:0]   s_on_c;
    logic [W:0]   s_off_c;
    logic         clr_c;

    assign last_c    = (cnt == W'(TOTAL - 1));
    assign nxt_c     = last_c ? '0 : cnt + W'(1);
    assign nxt_ext_c = {1'b0, nxt_c};

    // Sync edges computed one bit wider so a negative nudge cannot alias across zero
    assign s_on_c  = (W+1)'(START) + {{(W-3){ofs[3]}}, ofs};
    assign s_off_c = s_on_c + (W+1)'(SWIDTH);

    // Counter value 0 out of reset counts as the cycle just after a wrap when ZERO_CLR is set
    assign clr_c = (nxt_c == '0) || (ZERO_CLR && (cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            blank <= 1'b1;
            sync  <= ~POL;
        end else if (adv) begin
            cnt <= nxt_c;
            if (clr_c) begin
                blank <= 1'b0;
            end else if (nxt_c == W'(ACTIVE)) begin
                blank <= 1'b1;
            end
            if (nxt_ext_c == s_on_c) begin
                sync <= POL;
            end else if (nxt_ext_c == s_off_c) begin
                sync <= ~POL;
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V axes, per-frame sync nudge, line/frame strobes and blanked RGB.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HW       = 9,
    parameter int unsigned VW       = 9,
    parameter int unsigned RGB_W    = 8,
    parameter int unsigned H_TOTAL  = ARC448_H_TOTAL,
    parameter int unsigned H_ACTIVE = ARC448_H_ACTIVE,
    parameter int unsigned HS_START = ARC448_HS_START,
    parameter int unsigned HS_WIDTH = ARC448_HS_WIDTH,
    parameter int unsigned V_TOTAL  = ARC448_V_TOTAL,
    parameter int unsigned V_ACTIVE = ARC448_V_ACTIVE,
    parameter int unsigned VS_START = ARC448_VS_START,
    parameter int unsigned VS_WIDTH = ARC448_VS_WIDTH,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             PCLK_EN,
    input  logic [3:0]       HOFS,
    input  logic [3:0]       VOFS,
    input  logic [RGB_W-1:0] iRGB,
    output logic [HW-1:0]    HPOS,
    output logic [VW-1:0]    VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             LINE_START,
    output logic             FRAME_START
);

    localparam bit CFG_OK =
        axis_legal(H_TOTAL, H_ACTIVE, HS_START, HS_WIDTH, HW) &&
        axis_legal(V_TOTAL, V_ACTIVE, VS_START, VS_WIDTH, VW);

    logic [HW-1:0] hcnt;
    logic          h_last_c;
    logic          v_last_c;
    logic          h_wrap_c;
    logic          f_wrap_c;
    logic [3:0]    ofs_h;
    logic [3:0]    ofs_v;

    timing_axis #(
        .W(HW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .START(HS_START),
        .SWIDTH(HS_WIDTH), .POL(HS_POL), .ZERO_CLR(1'b1)
    ) u_h (
        .clk(MCLK), .rst(RESET), .adv(PCLK_EN), .ofs(ofs_h),
        .cnt(hcnt), .last_c(h_last_c), .blank(HBLK), .sync(HSYN)
    );

    assign h_wrap_c = PCLK_EN & h_last_c;

    timing_axis #(
        .W(VW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .START(VS_START),
        .SWIDTH(VS_WIDTH), .POL(VS_POL), .ZERO_CLR(1'b0)
    ) u_v (
        .clk(MCLK), .rst(RESET), .adv(h_wrap_c), .ofs(ofs_v),
        .cnt(VPOS), .last_c(v_last_c), .blank(VBLK), .sync(VSYN)
    );

    assign f_wrap_c = h_wrap_c & v_last_c;

    // Strobes run every MCLK so they stay one MCLK wide; the rest advances with PCLK_EN
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            oRGB        <= '0;
            HPOS        <= '1;
            ofs_h       <= '0;
            ofs_v       <= '0;
        end else begin
            LINE_START  <= h_wrap_c;
            FRAME_START <= f_wrap_c;
            if (PCLK_EN) begin
                oRGB <= (HBLK | VBLK) ? '0 : iRGB;
                HPOS <= h_last_c ? '1 : hcnt;
            end
            if (f_wrap_c) begin
                ofs_h <= HOFS;
                ofs_v <= VOFS;
            end
        end
    end

    always_ff @(posedge MCLK) begin : cfg_check
        assert (CFG_OK) else $error("video_timing_gen: illegal timing configuration");
    end

endmodule
